// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared register-file types for the tinyriscv core
package tinyriscv_pkg;
  localparam int RegNum = 32;
  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;
endpackage

// File: rtl/wb_arb.sv
// rtl/wb_arb.sv - writeback arbiter: ex/mem/div register-file write port with starvation guard
// and a pending-write scoreboard for long-latency results.
module wb_arb
  import tinyriscv_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      ex_we_i,
  input  RegAddrBus ex_waddr_i,
  input  RegBus     ex_wdata_i,
  output logic      ex_stall_o,
  input  logic      mem_valid_i,
  output logic      mem_ready_o,
  input  RegAddrBus mem_waddr_i,
  input  RegBus     mem_wdata_i,
  input  logic      div_valid_i,
  output logic      div_ready_o,
  input  RegAddrBus div_waddr_i,
  input  RegBus     div_wdata_i,
  input  logic      issue_en_i,
  input  RegAddrBus issue_waddr_i,
  input  RegAddrBus raddr1_i,
  input  RegAddrBus raddr2_i,
  output logic      hazard1_o,
  output logic      hazard2_o,
  output logic      we_o,
  output RegAddrBus waddr_o,
  output RegBus     wdata_o
);
  localparam int AW = $clog2(MEM_FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SRC_NONE, SRC_EX, SRC_MEM, SRC_DIV} src_e;

  RegAddrBus         r_fifo_addr [MEM_FIFO_DEPTH];
  RegBus             r_fifo_data [MEM_FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [SW-1:0]     r_starve_cnt;
  logic [RegNum-1:0] r_pending;

  logic [AW:0]       w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_starved;
  logic              w_ex_cand;
  logic              w_mem_cand;
  logic              w_div_cand;
  logic              w_lc_commit;
  src_e              w_sel;
  RegAddrBus         w_sel_addr;
  RegBus             w_sel_data;
  logic [RegNum-1:0] w_one;
  logic [RegNum-1:0] w_set_mask;
  logic [RegNum-1:0] w_clr_mask;

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign mem_ready_o = rst_ni && (w_count < (AW+1)'(MEM_FIFO_DEPTH));
  assign w_push      = mem_valid_i && mem_ready_o;

  // Every candidate is masked by reset so all outputs sit at zero while rst_ni is low.
  assign w_ex_cand   = rst_ni && ex_we_i;
  assign w_mem_cand  = rst_ni && (w_count != '0);
  assign w_div_cand  = rst_ni && div_valid_i;
  assign w_starved   = (r_starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    w_sel = SRC_NONE;
    if (w_starved) begin
      if (w_mem_cand)      w_sel = SRC_MEM;
      else if (w_div_cand) w_sel = SRC_DIV;
      else if (w_ex_cand)  w_sel = SRC_EX;
    end else begin
      if (w_ex_cand)       w_sel = SRC_EX;
      else if (w_mem_cand) w_sel = SRC_MEM;
      else if (w_div_cand) w_sel = SRC_DIV;
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    case (w_sel)
      SRC_EX: begin
        w_sel_addr = ex_waddr_i;
        w_sel_data = ex_wdata_i;
      end
      SRC_MEM: begin
        w_sel_addr = r_fifo_addr[r_rd_ptr[AW-1:0]];
        w_sel_data = r_fifo_data[r_rd_ptr[AW-1:0]];
      end
      SRC_DIV: begin
        w_sel_addr = div_waddr_i;
        w_sel_data = div_wdata_i;
      end
      default: begin
        w_sel_addr = '0;
        w_sel_data = '0;
      end
    endcase
  end

  assign we_o        = (w_sel != SRC_NONE) && (w_sel_addr != '0);
  assign waddr_o     = w_sel_addr;
  assign wdata_o     = w_sel_data;
  assign ex_stall_o  = w_ex_cand && (w_sel != SRC_EX);
  assign div_ready_o = (w_sel == SRC_DIV);
  assign w_pop       = (w_sel == SRC_MEM);
  assign w_lc_commit = (w_sel == SRC_MEM) || (w_sel == SRC_DIV);

  // Set is applied after clear so an issue and a retire to the same register keep it pending.
  assign w_one      = {{(RegNum-1){1'b0}}, 1'b1};
  assign w_set_mask = (issue_en_i && (issue_waddr_i != '0)) ? (w_one << issue_waddr_i) : '0;
  assign w_clr_mask = w_lc_commit ? (w_one << w_sel_addr) : '0;

  assign hazard1_o = rst_ni && (raddr1_i != '0) && r_pending[raddr1_i]
                     && !(w_lc_commit && (w_sel_addr == raddr1_i));
  assign hazard2_o = rst_ni && (raddr2_i != '0) && r_pending[raddr2_i]
                     && !(w_lc_commit && (w_sel_addr == raddr2_i));

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[AW-1:0]] <= mem_waddr_i;
      r_fifo_data[r_wr_ptr[AW-1:0]] <= mem_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_starve_cnt <= '0;
      r_pending    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_lc_commit)
        r_starve_cnt <= '0;
      else if ((w_mem_cand || w_div_cand) && !w_starved)
        r_starve_cnt <= r_starve_cnt + SW'(1);
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~w_one;
    end
  end
endmodule

// File: tb/tb_wb_arb.sv
// tb/tb_wb_arb.sv - self-checking bench for wb_arb: queue-based reference model plus directed cases
module tb_wb_arb;
  import tinyriscv_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      ex_we, ex_stall;
  RegAddrBus ex_waddr;
  RegBus     ex_wdata;
  logic      mem_valid, mem_ready;
  RegAddrBus mem_waddr;
  RegBus     mem_wdata;
  logic      div_valid, div_ready;
  RegAddrBus div_waddr;
  RegBus     div_wdata;
  logic      issue_en;
  RegAddrBus issue_waddr, raddr1, raddr2;
  logic      hazard1, hazard2, we;
  RegAddrBus waddr;
  RegBus     wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arb #(.MEM_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_stall_o(ex_stall),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .div_valid_i(div_valid), .div_ready_o(div_ready), .div_waddr_i(div_waddr), .div_wdata_i(div_wdata),
    .issue_en_i(issue_en), .issue_waddr_i(issue_waddr),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .hazard1_o(hazard1), .hazard2_o(hazard2),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: load buffer as a queue, wait counter as an int, pending set as a bit array.
  logic [36:0] q[$];
  int          starve = 0;
  bit          pend[32];
  int          m_src = 0;
  bit          m_cand = 0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always @(negedge clk) begin : cmp_proc
    logic e_we, e_stall, e_dr, e_mr, e_h1, e_h2;
    m_src  = 0;
    m_addr = '0;
    m_data = '0;
    m_cand = 0;
    if (rst_n) begin
      m_cand = (q.size() > 0) || div_valid;
      if (starve >= LIMIT) begin
        if (q.size() > 0)   m_src = 2;
        else if (div_valid) m_src = 3;
        else if (ex_we)     m_src = 1;
      end else begin
        if (ex_we)             m_src = 1;
        else if (q.size() > 0) m_src = 2;
        else if (div_valid)    m_src = 3;
      end
      if (m_src == 1) begin m_addr = ex_waddr;  m_data = ex_wdata;  end
      if (m_src == 2) begin m_addr = q[0][36:32]; m_data = q[0][31:0]; end
      if (m_src == 3) begin m_addr = div_waddr; m_data = div_wdata; end
    end
    e_we    = (m_src != 0) && (m_addr != 0);
    e_stall = rst_n && ex_we && (m_src != 1);
    e_dr    = (m_src == 3);
    e_mr    = rst_n && (q.size() < DEPTH);
    e_h1    = rst_n && (raddr1 != 0) && pend[raddr1] && !(m_src >= 2 && m_addr == raddr1);
    e_h2    = rst_n && (raddr2 != 0) && pend[raddr2] && !(m_src >= 2 && m_addr == raddr2);
    chk("cyc_we",        32'(we),        32'(e_we));
    chk("cyc_waddr",     32'(waddr),     32'(m_addr));
    chk("cyc_wdata",     wdata,          m_data);
    chk("cyc_ex_stall",  32'(ex_stall),  32'(e_stall));
    chk("cyc_div_ready", 32'(div_ready), 32'(e_dr));
    chk("cyc_mem_ready", 32'(mem_ready), 32'(e_mr));
    chk("cyc_hazard1",   32'(hazard1),   32'(e_h1));
    chk("cyc_hazard2",   32'(hazard2),   32'(e_h2));
  end

  always @(posedge clk) begin : model_proc
    bit acc;
    if (!rst_n) begin
      q.delete();
      starve = 0;
      foreach (pend[i]) pend[i] = 0;
    end else begin
      acc = mem_valid && (q.size() < DEPTH);
      if (m_src == 2) void'(q.pop_front());
      if (acc) q.push_back({mem_waddr, mem_wdata});
      if (m_src >= 2) starve = 0;
      else if (m_cand && starve < LIMIT) starve++;
      if (m_src >= 2) pend[m_addr] = 0;
      if (issue_en && issue_waddr != 0) pend[issue_waddr] = 1;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_we = 0; ex_waddr = '0; ex_wdata = '0;
    mem_valid = 0; mem_waddr = '0; mem_wdata = '0;
    div_valid = 0; div_waddr = '0; div_wdata = '0;
    issue_en = 0; issue_waddr = '0;
  endtask

  initial begin
    idle();
    rst_n = 0; raddr1 = '0; raddr2 = '0;
    nxt();
    ex_we = 1; ex_waddr = 5; ex_wdata = 32'h1234;
    mem_valid = 1; mem_waddr = 4; div_valid = 1; div_waddr = 6;
    #2;
    chk("rst_we", 32'(we), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_ex_stall", 32'(ex_stall), 0);
    chk("rst_div_ready", 32'(div_ready), 0);
    nxt();
    idle(); rst_n = 1;
    nxt();

    ex_we = 1; ex_waddr = 5; ex_wdata = 32'h1234; #2;
    chk("ex_we", 32'(we), 1);
    chk("ex_waddr", 32'(waddr), 5);
    chk("ex_wdata", wdata, 32'h1234);
    chk("ex_stall", 32'(ex_stall), 0);
    nxt(); idle();
    ex_we = 1; ex_waddr = 0; ex_wdata = 32'hdead; #2;
    chk("ex_x0_we", 32'(we), 0);
    chk("ex_x0_stall", 32'(ex_stall), 0);
    nxt(); idle();

    issue_en = 1; issue_waddr = 7; raddr1 = 7; #2;
    chk("ld_issue_hz", 32'(hazard1), 0);
    nxt(); issue_en = 0; mem_valid = 1; mem_waddr = 7; mem_wdata = 32'h77; #2;
    chk("ld_push_hz", 32'(hazard1), 1);
    chk("ld_no_bypass", 32'(we), 0);
    nxt(); mem_valid = 0; #2;
    chk("ld_commit_we", 32'(we), 1);
    chk("ld_commit_waddr", 32'(waddr), 7);
    chk("ld_commit_wdata", wdata, 32'h77);
    chk("ld_commit_hz", 32'(hazard1), 0);
    nxt(); #2;
    chk("ld_after_hz", 32'(hazard1), 0);

    nxt(); ex_we = 1; ex_waddr = 9; ex_wdata = 32'h99;
    mem_valid = 1; mem_waddr = 10; mem_wdata = 32'ha0;
    nxt(); mem_waddr = 11; mem_wdata = 32'hb0;
    nxt(); mem_waddr = 12; mem_wdata = 32'hc0; #2;
    chk("st_full_ready", 32'(mem_ready), 0);
    nxt(); #2;
    chk("st_k4_waddr", 32'(waddr), 9);
    nxt();
    nxt(); #2;
    chk("st_pre_we", 32'(we), 1);
    chk("st_pre_waddr", 32'(waddr), 10);
    chk("st_pre_wdata", wdata, 32'ha0);
    chk("st_pre_stall", 32'(ex_stall), 1);
    nxt(); #2;
    chk("st_after_ready", 32'(mem_ready), 1);
    nxt(); mem_valid = 0; ex_we = 0;
    repeat (3) nxt();

    ex_we = 1; ex_waddr = 9; div_valid = 1; div_waddr = 13; div_wdata = 32'hd0;
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk("dv_wait_ready", 32'(div_ready), 0);
      nxt();
    end
    #2;
    chk("dv_5th_ready", 32'(div_ready), 1);
    chk("dv_5th_waddr", 32'(waddr), 13);
    nxt(); #2;
    chk("dv_cleared_ready", 32'(div_ready), 0);
    nxt(); idle();

    div_valid = 1; div_waddr = 3; div_wdata = 32'h33;
    issue_en = 1; issue_waddr = 3; raddr1 = 3; #2;
    chk("sc_same_ready", 32'(div_ready), 1);
    chk("sc_same_hz", 32'(hazard1), 0);
    nxt(); idle(); #2;
    chk("sc_next_hz", 32'(hazard1), 1);
    nxt(); div_valid = 1; div_waddr = 3; #2;
    chk("sc_retire_hz", 32'(hazard1), 0);
    nxt(); idle(); #2;
    chk("sc_cleared_hz", 32'(hazard1), 0);
    nxt(); div_valid = 1; div_waddr = 0; div_wdata = 32'h55;
    issue_en = 1; issue_waddr = 0; #2;
    chk("x0_div_we", 32'(we), 0);
    chk("x0_div_ready", 32'(div_ready), 1);
    nxt(); idle();

    issue_en = 1; issue_waddr = 20; raddr2 = 20;
    ex_we = 1; ex_waddr = 9; mem_valid = 1; mem_waddr = 21; mem_wdata = 32'h21;
    nxt(); issue_en = 0; mem_waddr = 22; mem_wdata = 32'h22; #2;
    chk("rr_pre_hz2", 32'(hazard2), 1);
    nxt(); idle(); rst_n = 0; #2;
    chk("rr_in_we", 32'(we), 0);
    chk("rr_in_ready", 32'(mem_ready), 0);
    chk("rr_in_hz2", 32'(hazard2), 0);
    nxt(); rst_n = 1; #2;
    chk("rr_rel_ready", 32'(mem_ready), 1);
    chk("rr_rel_we", 32'(we), 0);
    chk("rr_rel_hz2", 32'(hazard2), 0);
    nxt(); #2;
    chk("rr_post_we", 32'(we), 0);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
